// File: rtl/prg_uploader.sv
// -----------------------------------------------------------------------------
// prg_uploader
//
// Saves the BASIC program held in on-chip RAM to the HPS as a .PRG file. This is
// the read-out counterpart of the PRG downloader.
//
// When the OSD save trigger rises, the block:
//   1. reads the 16-bit little-endian end-of-program pointer,
//   2. sizes the file from that pointer,
//   3. asks the HPS to start an upload,
//   4. answers each ioctl_rd strobe with a byte read from RAM.
//
// While it owns the RAM read port, the block holds 'uploading' high. The top
// level uses that signal to keep the Z80 in WAIT.
//
// Optional feature: when LM80C_PRG_HEADER_EN is defined, the file starts with a
// 2-byte load-address header: PRG_START low byte, then PRG_START high byte.
//
// Ports
//   clk               in   system clock (clk_sys)
//   reset             in   synchronous, active-high
//   trigger           in   save request from OSD; a rising edge starts a save
//   ioctl_upload      in   HPS upload in progress
//   ioctl_index       in   [7:0]  HPS file index
//   ioctl_addr        in   [24:0] file byte offset requested by the HPS
//   ioctl_rd          in   HPS read strobe, 1 clk wide
//   ioctl_din         out  [7:0]  byte returned to the HPS
//   ioctl_upload_req  out  asks the HPS to start an upload
//   uploading         out  block owns the RAM read port (CPU must WAIT)
//   file_len          out  [15:0] file length in bytes
//   mem_addr          out  [15:0] RAM read address (CPU address space)
//   mem_rd            out  RAM read enable
//   mem_data          in   [7:0]  RAM read data, valid 1 clk after mem_rd
//   done              out  1-clk pulse: upload finished
//   error             out  1-clk pulse: invalid pointer, save aborted
// -----------------------------------------------------------------------------
module prg_uploader #(
   parameter logic [15:0] PRG_START    = 16'h560F,
   parameter logic [15:0] PTR_PROGND   = 16'h55EB,
   parameter logic [7:0]  UPLOAD_INDEX = 8'd2,
   parameter logic [7:0]  PAD_BYTE     = 8'h00
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        trigger,
   input  logic        ioctl_upload,
   input  logic [7:0]  ioctl_index,
   input  logic [24:0] ioctl_addr,
   input  logic        ioctl_rd,
   output logic [7:0]  ioctl_din,
   output logic        ioctl_upload_req,
   output logic        uploading,
   output logic [15:0] file_len,
   output logic [15:0] mem_addr,
   output logic        mem_rd,
   input  logic [7:0]  mem_data,
   output logic        done,
   output logic        error
);

`ifdef LM80C_PRG_HEADER_EN
   localparam logic [15:0] HDR_LEN = 16'd2;
`else
   localparam logic [15:0] HDR_LEN = 16'd0;
`endif

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PTR_LO,
      ST_PTR_HI,
      ST_CHECK,
      ST_REQ,
      ST_SERVE,
      ST_FINISH
   } state_t;

   state_t      state_reg, state_next;
   logic        trigger_q_reg;
   logic        upload_q_reg;
   logic [7:0]  ptr_lo_reg;
   logic [15:0] file_len_reg;
   logic        error_reg;
   logic [7:0]  din_reg;

   // Stage 1 of the read pipeline. It records what the strobe of the previous
   // clock asked for, so the result can be written on the following clock.
   logic        p1_valid_reg;
   logic        p1_ram_reg;
   logic [7:0]  p1_byte_reg;

   logic        trigger_rise;
   logic [15:0] ptr_full;
   logic        ptr_ok;
   logic [15:0] prog_len;
   logic        serve_rd;
   logic        in_file;
   logic [15:0] prog_off;
   logic        rd_use_ram;
   logic [7:0]  rd_byte;
   logic [15:0] rd_addr;
   logic [15:0] mem_addr_next;
   logic        mem_rd_next;

   assign trigger_rise = trigger & ~trigger_q_reg;

   // In CHECK, the high pointer byte is still on mem_data (it was read in
   // PTR_HI). It is therefore used directly rather than latched first.
   assign ptr_full = {mem_data, ptr_lo_reg};
   assign ptr_ok   = (ptr_full > PRG_START);
   assign prog_len = ptr_full - PRG_START;

   assign serve_rd = (state_reg == ST_SERVE) && ioctl_rd;

   // Compare the full 25-bit offset. Offsets of 2^16 and above can then never
   // alias back into RAM.
   assign in_file  = (ioctl_addr < {9'd0, file_len_reg});
   assign prog_off = ioctl_addr[15:0] - HDR_LEN;
   assign rd_addr  = PRG_START + prog_off;

   // Decode the strobe: read from RAM, return a header byte, or return padding.
   always_comb begin
      rd_use_ram = 1'b0;
      rd_byte    = PAD_BYTE;
      if (in_file) begin
`ifdef LM80C_PRG_HEADER_EN
         if (ioctl_addr[15:0] == 16'd0) begin
            rd_byte = PRG_START[7:0];
         end else if (ioctl_addr[15:0] == 16'd1) begin
            rd_byte = PRG_START[15:8];
         end else begin
            rd_use_ram = 1'b1;
         end
`else
         rd_use_ram = 1'b1;
`endif
      end
   end

   // Next-state logic and RAM port drive.
   always_comb begin
      state_next    = state_reg;
      mem_addr_next = 16'h0000;
      mem_rd_next   = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (trigger_rise) begin
               state_next = ST_PTR_LO;
            end
         end
         ST_PTR_LO: begin
            mem_addr_next = PTR_PROGND;
            mem_rd_next   = 1'b1;
            state_next    = ST_PTR_HI;
         end
         ST_PTR_HI: begin
            mem_addr_next = PTR_PROGND + 16'd1;
            mem_rd_next   = 1'b1;
            state_next    = ST_CHECK;
         end
         ST_CHECK: begin
            state_next = ptr_ok ? ST_REQ : ST_IDLE;
         end
         ST_REQ: begin
            if (ioctl_upload && (ioctl_index == UPLOAD_INDEX)) begin
               state_next = ST_SERVE;
            end
         end
         ST_SERVE: begin
            if (serve_rd && rd_use_ram) begin
               mem_addr_next = rd_addr;
               mem_rd_next   = 1'b1;
            end
            if (upload_q_reg && !ioctl_upload) begin
               state_next = ST_FINISH;
            end
         end
         ST_FINISH: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= ST_IDLE;
         trigger_q_reg <= 1'b0;
         upload_q_reg  <= 1'b0;
         ptr_lo_reg    <= 8'h00;
         file_len_reg  <= 16'h0000;
         error_reg     <= 1'b0;
         din_reg       <= 8'h00;
         p1_valid_reg  <= 1'b0;
         p1_ram_reg    <= 1'b0;
         p1_byte_reg   <= 8'h00;
      end else begin
         state_reg     <= state_next;
         trigger_q_reg <= trigger;
         upload_q_reg  <= ioctl_upload;
         error_reg     <= (state_reg == ST_CHECK) && !ptr_ok;

         // The low pointer byte requested in PTR_LO arrives during PTR_HI.
         if (state_reg == ST_PTR_HI) begin
            ptr_lo_reg <= mem_data;
         end

         if ((state_reg == ST_CHECK) && ptr_ok) begin
            file_len_reg <= prog_len + HDR_LEN;
         end

         // Padding and header bytes also take two clocks. Keeping every result
         // at the same latency means back-to-back strobes complete in order.
         p1_valid_reg <= serve_rd;
         p1_ram_reg   <= rd_use_ram;
         p1_byte_reg  <= rd_byte;
         if (p1_valid_reg) begin
            din_reg <= p1_ram_reg ? mem_data : p1_byte_reg;
         end
      end
   end

   assign ioctl_din        = din_reg;
   assign ioctl_upload_req = (state_reg == ST_REQ);
   assign uploading        = (state_reg != ST_IDLE);
   assign file_len         = file_len_reg;
   assign mem_addr         = mem_addr_next;
   assign mem_rd           = mem_rd_next;
   assign done             = (state_reg == ST_FINISH);
   assign error            = error_reg;

endmodule

// File: tb/tb_prg_uploader.sv
// -----------------------------------------------------------------------------
// tb_prg_uploader
//
// Directed testbench for prg_uploader.
//   - A 64 KiB RAM model with registered read sits behind mem_addr/mem_rd.
//   - Inputs are driven on the falling clock edge.
//   - Outputs are sampled on the falling edge, or #1 after driving for the
//     combinational RAM port.
// Expected bytes come from the RAM contents the bench itself loaded.
// Expected lengths are hand-computed constants:
//   0x5700 - 0x560F = 0xF1, plus 2 when the header is enabled.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_prg_uploader;

   logic        clk = 1'b0;
   logic        reset;
   logic        trigger;
   logic        ioctl_upload;
   logic [7:0]  ioctl_index;
   logic [24:0] ioctl_addr;
   logic        ioctl_rd;
   logic [7:0]  ioctl_din;
   logic        ioctl_upload_req;
   logic        uploading;
   logic [15:0] file_len;
   logic [15:0] mem_addr;
   logic        mem_rd;
   logic [7:0]  mem_data;
   logic        done;
   logic        error;

   int tests_run    = 0;
   int tests_failed = 0;

`ifdef LM80C_PRG_HEADER_EN
   localparam logic [15:0] EXP_LEN = 16'h00F3;
   localparam logic [15:0] HDR     = 16'd2;
`else
   localparam logic [15:0] EXP_LEN = 16'h00F1;
   localparam logic [15:0] HDR     = 16'd0;
`endif

   logic [7:0] ram [0:65535];

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_rd) mem_data <= ram[mem_addr];
   end

   prg_uploader dut (
      .clk              (clk),
      .reset            (reset),
      .trigger          (trigger),
      .ioctl_upload     (ioctl_upload),
      .ioctl_index      (ioctl_index),
      .ioctl_addr       (ioctl_addr),
      .ioctl_rd         (ioctl_rd),
      .ioctl_din        (ioctl_din),
      .ioctl_upload_req (ioctl_upload_req),
      .uploading        (uploading),
      .file_len         (file_len),
      .mem_addr         (mem_addr),
      .mem_rd           (mem_rd),
      .mem_data         (mem_data),
      .done             (done),
      .error            (error)
   );

   task automatic tick();
      @(negedge clk);
   endtask

   function automatic logic [7:0] exp_byte(input logic [24:0] off);
      logic [15:0] a;
      if (off >= {9'd0, EXP_LEN}) return 8'h00;
`ifdef LM80C_PRG_HEADER_EN
      if (off == 25'd0) return 8'h0F;
      if (off == 25'd1) return 8'h56;
`endif
      a = 16'h560F + off[15:0] - HDR;
      return ram[a];
   endfunction

   // Stimulus helper. Writes the pointer, pulses trigger and waits (bounded)
   // for the upload request. The caller checks got_req.
   task automatic start_save(input logic [15:0] ptr, output bit got_req);
      ram[16'h55EB] = ptr[7:0];
      ram[16'h55EC] = ptr[15:8];
      trigger = 1'b1;
      tick();
      trigger = 1'b0;
      got_req = 1'b0;
      for (int i = 0; i < 10 && !got_req; i++) begin
         if (ioctl_upload_req) got_req = 1'b1;
         else tick();
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      tick();
      tests_run++;
      if ({ioctl_din, ioctl_upload_req, uploading, file_len, mem_addr, mem_rd, done, error} !== '0) begin
         tests_failed++;
         $display("FAIL reset_outputs: din=%h req=%b upl=%b len=%h addr=%h rd=%b done=%b err=%b, required all 0",
                  ioctl_din, ioctl_upload_req, uploading, file_len, mem_addr, mem_rd, done, error);
      end
      $display("[TB] reset checked");
   endtask

   task automatic test_save();
      ram[16'h55EB] = 8'h00;
      ram[16'h55EC] = 8'h57;
      trigger = 1'b1;
      tick();
      trigger = 1'b0;

      // PTR_LO
      tests_run++;
      if (!(uploading === 1'b1 && mem_rd === 1'b1 && mem_addr === 16'h55EB)) begin
         tests_failed++;
         $display("FAIL ptr_lo_read: upl=%b rd=%b addr=%h, required 1 1 55eb", uploading, mem_rd, mem_addr);
      end

      // PTR_HI
      tick();
      tests_run++;
      if (!(mem_rd === 1'b1 && mem_addr === 16'h55EC)) begin
         tests_failed++;
         $display("FAIL ptr_hi_read: rd=%b addr=%h, required 1 55ec", mem_rd, mem_addr);
      end

      // CHECK, then REQ
      tick();
      tick();
      tests_run++;
      if (ioctl_upload_req !== 1'b1) begin
         tests_failed++;
         $display("FAIL upload_req_raise: got %b, required 1", ioctl_upload_req);
      end
      tests_run++;
      if (file_len !== EXP_LEN) begin
         tests_failed++;
         $display("FAIL file_len: got %h, required %h", file_len, EXP_LEN);
      end

      // An upload with the wrong index must not be serviced.
      ioctl_upload = 1'b1;
      ioctl_index  = 8'd1;
      tick();
      tick();
      tick();
      tests_run++;
      if (ioctl_upload_req !== 1'b1) begin
         tests_failed++;
         $display("FAIL req_wrong_index: req=%b, required 1", ioctl_upload_req);
      end

      ioctl_index = 8'd2;
      tick();
      tests_run++;
      if (!(ioctl_upload_req === 1'b0 && uploading === 1'b1)) begin
         tests_failed++;
         $display("FAIL req_drop: req=%b upl=%b, required 0 1", ioctl_upload_req, uploading);
      end
      $display("[TB] save started len=%h", file_len);
   endtask

   task automatic test_single_reads();
      logic [24:0] offs [8];
      logic [7:0]  prev;
      logic [7:0]  exp;
      logic        exp_rd;
      logic [15:0] exp_addr;

      offs = '{25'h0, 25'h1, 25'h2, 25'hF0, 25'hF1, 25'hF2, 25'hF3, 25'h10002};
      for (int i = 0; i < 8; i++) begin
         exp      = exp_byte(offs[i]);
         exp_rd   = (offs[i] < {9'd0, EXP_LEN}) && (offs[i] >= {9'd0, HDR});
         exp_addr = 16'h560F + offs[i][15:0] - HDR;
         prev     = ioctl_din;

         ioctl_addr = offs[i];
         ioctl_rd   = 1'b1;
         #1;
         tests_run++;
         if (mem_rd !== exp_rd || (exp_rd && mem_addr !== exp_addr)) begin
            tests_failed++;
            $display("FAIL rd_port off=%h: rd=%b addr=%h, required rd=%b addr=%h",
                     offs[i], mem_rd, mem_addr, exp_rd, exp_addr);
         end

         tick();
         ioctl_rd = 1'b0;
         tests_run++;
         if (ioctl_din !== prev) begin
            tests_failed++;
            $display("FAIL din_early off=%h: got %h, required still %h", offs[i], ioctl_din, prev);
         end

         tick();
         tests_run++;
         if (ioctl_din !== exp) begin
            tests_failed++;
            $display("FAIL din off=%h: got %h, required %h", offs[i], ioctl_din, exp);
         end
         $display("[TB] rd off=%h din=%h", offs[i], ioctl_din);
      end
   endtask

   task automatic test_back_to_back();
      ioctl_addr = 25'd5;
      ioctl_rd   = 1'b1;
      tick();
      ioctl_addr = 25'd6;
      tick();
      ioctl_rd = 1'b0;
      tests_run++;
      if (ioctl_din !== exp_byte(25'd5)) begin
         tests_failed++;
         $display("FAIL b2b_first: got %h, required %h", ioctl_din, exp_byte(25'd5));
      end
      tick();
      tests_run++;
      if (ioctl_din !== exp_byte(25'd6)) begin
         tests_failed++;
         $display("FAIL b2b_second: got %h, required %h", ioctl_din, exp_byte(25'd6));
      end
      $display("[TB] back-to-back rd 5,6 din=%h", ioctl_din);
   endtask

   task automatic test_trigger_ignored();
      trigger = 1'b1;
      tick();
      trigger = 1'b0;
      tests_run++;
      if (mem_rd !== 1'b0) begin
         tests_failed++;
         $display("FAIL trig_in_serve_rd: mem_rd=%b, required 0", mem_rd);
      end
      tick();
      tick();
      tick();
      tests_run++;
      if (!(uploading === 1'b1 && ioctl_upload_req === 1'b0)) begin
         tests_failed++;
         $display("FAIL trig_in_serve_state: upl=%b req=%b, required 1 0", uploading, ioctl_upload_req);
      end
      $display("[TB] trigger during serve ignored");
   endtask

   task automatic test_done();
      ioctl_upload = 1'b0;
      tick();
      tests_run++;
      if (!(done === 1'b1 && uploading === 1'b1)) begin
         tests_failed++;
         $display("FAIL done_pulse: done=%b upl=%b, required 1 1", done, uploading);
      end
      tick();
      tests_run++;
      if (!(done === 1'b0 && uploading === 1'b0)) begin
         tests_failed++;
         $display("FAIL done_end: done=%b upl=%b, required 0 0", done, uploading);
      end
      tests_run++;
      if (file_len !== EXP_LEN) begin
         tests_failed++;
         $display("FAIL len_retained: got %h, required %h", file_len, EXP_LEN);
      end
      $display("[TB] upload finished");
   endtask

   task automatic test_rd_outside();
      logic [7:0] prev;
      prev       = ioctl_din;
      ioctl_addr = 25'd0;
      ioctl_rd   = 1'b1;
      #1;
      tests_run++;
      if (mem_rd !== 1'b0) begin
         tests_failed++;
         $display("FAIL idle_rd_port: mem_rd=%b, required 0", mem_rd);
      end
      tick();
      ioctl_rd = 1'b0;
      tick();
      tick();
      tests_run++;
      if (ioctl_din !== prev) begin
         tests_failed++;
         $display("FAIL idle_rd_din: got %h, required %h", ioctl_din, prev);
      end
      $display("[TB] rd in idle ignored");
   endtask

   task automatic test_error();
      logic [15:0] ptrs [2];
      int          err_cnt;
      int          low_at;
      bit          saw_req;

      ptrs = '{16'h560F, 16'h5000};
      for (int p = 0; p < 2; p++) begin
         ram[16'h55EB] = ptrs[p][7:0];
         ram[16'h55EC] = ptrs[p][15:8];
         trigger = 1'b1;
         tick();
         trigger = 1'b0;
         err_cnt = 0;
         low_at  = -1;
         saw_req = 1'b0;
         for (int i = 1; i <= 6; i++) begin
            if (error) err_cnt++;
            if (ioctl_upload_req) saw_req = 1'b1;
            if (!uploading && low_at < 0) low_at = i;
            tick();
         end
         tests_run++;
         if (err_cnt != 1 || saw_req) begin
            tests_failed++;
            $display("FAIL error_pulse ptr=%h: pulses=%0d req_seen=%b, required 1 0", ptrs[p], err_cnt, saw_req);
         end
         tests_run++;
         if (low_at < 2 || low_at > 4) begin
            tests_failed++;
            $display("FAIL error_uploading ptr=%h: low after %0d clk, required 2..4", ptrs[p], low_at);
         end
         tests_run++;
         if (file_len !== EXP_LEN) begin
            tests_failed++;
            $display("FAIL error_len_kept ptr=%h: got %h, required %h", ptrs[p], file_len, EXP_LEN);
         end
         $display("[TB] bad pointer %h aborted", ptrs[p]);
      end
   endtask

   task automatic test_reset_mid();
      bit got;
      start_save(16'h5700, got);
      tests_run++;
      if (!got) begin
         tests_failed++;
         $display("FAIL reset_mid_req: upload_req=0 after 10 clk, required 1");
      end
      ioctl_upload = 1'b1;
      ioctl_index  = 8'd2;
      tick();
      ioctl_addr = 25'd0;
      ioctl_rd   = 1'b1;
      reset      = 1'b1;
      tick();
      reset = 1'b0;
      tests_run++;
      if ({ioctl_din, ioctl_upload_req, uploading, file_len, mem_addr, mem_rd, done, error} !== '0) begin
         tests_failed++;
         $display("FAIL reset_mid: din=%h req=%b upl=%b len=%h addr=%h rd=%b done=%b err=%b, required all 0",
                  ioctl_din, ioctl_upload_req, uploading, file_len, mem_addr, mem_rd, done, error);
      end
      ioctl_rd = 1'b0;
      tick();
      tests_run++;
      if (!(ioctl_din === 8'h00 && uploading === 1'b0)) begin
         tests_failed++;
         $display("FAIL reset_mid_after: din=%h upl=%b, required 00 0", ioctl_din, uploading);
      end
      ioctl_upload = 1'b0;
      tick();
      $display("[TB] reset during serve");
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) ram[i] = 8'(i) ^ 8'(i >> 8) ^ 8'hA5;
      reset        = 1'b1;
      trigger      = 1'b0;
      ioctl_upload = 1'b0;
      ioctl_index  = 8'd0;
      ioctl_addr   = 25'd0;
      ioctl_rd     = 1'b0;

      test_reset();
      test_save();
      test_single_reads();
      test_back_to_back();
      test_trigger_ignored();
      test_done();
      test_rd_outside();
      test_error();
      test_reset_mid();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
